imm_instr_encoder: RTL and testbench
====================================

Name: imm_instr_encoder

Overview:
- Inverse of the pipeline's immediate-extraction path: packs opcode, register fields, funct fields and a 64-bit immediate into 32-bit instruction words.
- Streams encoded words into instruction memory through a write port with an auto-incrementing address.
- Used by the test/boot loader to build programs in instruction memory before the core leaves reset.
- Immediate placement is the exact inverse of the core's immediate generator, so a word written here decodes back to the same sign-extended immediate.

Parameters:
ADDR_W, 32, width of mem_addr (byte address)
BASE_ADDR, 0, byte address of the first word written after reset/restart
DEPTH, 64, maximum words per load session (must be >= 1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
restart  in  1  return from DONE to IDLE (ignored in other states)
in_valid  in  1  field bundle valid
in_ready  out  1  block can accept a bundle
in_last  in  1  final bundle of the program
opcode  in  7  instruction[6:0]
funct3  in  3  instruction[14:12]
funct7  in  7  R-type instruction[31:25]
rd  in  5  destination register
rs1  in  5  source register 1
rs2  in  5  source register 2
imm  in  64  signed immediate (two's complement)
mem_we  out  1  instruction-memory write strobe, one cycle per word
mem_addr  out  ADDR_W  byte address of mem_wdata
mem_wdata  out  32  encoded instruction
imm_err  out  1  current word's imm did not fit 12 bits (valid with mem_we)
err_any  out  1  sticky OR of imm_err since reset/restart
words_written  out  $clog2(DEPTH+1)  words written this session
done  out  1  session complete

Behaviour:
- Clock and reset: single clock clk; reset synchronous and active-high; reset has priority over every other input.
- Reset values: state=IDLE, in_ready=1, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, imm_err=0, err_any=0, words_written=0, done=0.
- Accept: a bundle is accepted on a rising edge when in_valid && in_ready. in_ready = (state != DONE). There is no backpressure from memory; it always accepts writes.
- Latency: 1 cycle. The cycle after an accept, mem_we=1 for exactly one cycle, with mem_wdata = encoded word and mem_addr = address assigned to that word. Back-to-back accepts give back-to-back writes.
- Address: the first write uses BASE_ADDR. After each write mem_addr advances by 4 and wraps modulo 2^ADDR_W.
- Format select is opcode[6:5]:
  - 00, I-type: {imm[11:0], rs1, funct3, rd, opcode}
  - 01 with opcode[4]=0, S-type: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - 01 with opcode[4]=1, R-type: {funct7, rs2, rs1, funct3, rd, opcode}. imm is ignored and imm_err=0.
  - 10 or 11, SB-type (12-bit field, no implicit shift): {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], opcode}
- Range check (I/S/SB): imm_err=1 unless imm[63:11] are all equal. The word is still written, using imm[11:0] truncated. err_any is set in the same cycle and stays set.
- FSM:
  - IDLE -> LOAD on the first accept.
  - LOAD -> DONE on an accept with in_last=1, or on the accept that makes words_written reach DEPTH.
  - DONE: holds, in_ready=0, done=1.
  - DONE -> IDLE on restart. This clears words_written and err_any and sets mem_addr=BASE_ADDR.
- done timing: done rises in the same cycle as the final mem_we.
- A first bundle with in_last=1 goes IDLE -> DONE directly.
- words_written increments in the same cycle as each mem_we.
- restart in IDLE or LOAD is ignored.
- Reset during LOAD: any pending write is dropped (no mem_we the next cycle), and all outputs return to their reset values.

Decomposition:
- Shared package holds:
  - format-select constants FMT_I=2'b00, FMT_S_R=2'b01, FMT_SB_A=2'b10, FMT_SB_B=2'b11
  - opcode constants (LOAD 0000011, STORE 0100011, OP 0110011, BRANCH 1100011)
  - FSM state encoding IDLE/LOAD/DONE
- One combinational sub-module, instr_pack, holds the field packing and range check. The top holds the FSM, address/count registers and output register stage.

Test Plan:
- I-type load: opcode=0000011, rd=5, rs1=2, funct3=011, imm=-8 -> next cycle mem_we=1, mem_addr=0, mem_wdata=0xFF813283, imm_err=0.
- S-type store: opcode=0100011, rs1=2, rs2=5, funct3=011, imm=16 -> mem_wdata=0x00513823, at mem_addr=4 if it follows the I-type word.
- SB-type branch: opcode=1100011, rs1=1, rs2=2, funct3=000, imm=-2 -> mem_wdata=0xFE208EE3. Feeding this word to the core's immediate generator returns 0xFFFFFFFFFFFFFFFE.
- Range error: I-type, imm=2048 -> word written with imm field 0x800, imm_err=1 for one cycle, err_any stays 1 until restart or reset.
- Depth limit: DEPTH=4, five consecutive valid bundles with in_last=0 -> writes at 0, 4, 8, 12; done=1 with the fourth write; in_ready=0; the fifth is never written. Then restart -> IDLE, next write at BASE_ADDR, words_written=1.
- Reset mid-load: accept a bundle and assert reset on the following edge -> no mem_we, mem_addr=BASE_ADDR, words_written=0, state IDLE.

Source files
------------

// File: rtl/imm_instr_encoder_pkg.sv
// Shared constants for the instruction encoder: format select, opcodes, FSM states.
package imm_instr_encoder_pkg;

  // Format select, taken from opcode[6:5]
  localparam logic [1:0] FMT_I    = 2'b00;
  localparam logic [1:0] FMT_S_R  = 2'b01;
  localparam logic [1:0] FMT_SB_A = 2'b10;
  localparam logic [1:0] FMT_SB_B = 2'b11;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // A 12-bit signed field holds imm only if imm[63:11] is pure sign extension.
  function automatic logic imm_fits12(input logic [63:0] imm);
    return (&imm[63:11]) | ~(|imm[63:11]);
  endfunction

endpackage

// File: rtl/imm_instr_encoder_pack.sv
// Combinational field packer: places register/funct/imm fields by format
// and flags immediates that do not fit the 12-bit field.
module instr_pack
  import imm_instr_encoder_pkg::*;
(
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [63:0] imm_i,
  output logic [31:0] word_o,
  output logic        imm_err_o
);

  logic [11:0] imm12;
  logic        fits;

  assign imm12 = imm_i[11:0];
  assign fits  = imm_fits12(imm_i);

  // Select layout on opcode[6:5]; R-type shares the 01 code with S-type, split by opcode[4].
  always_comb begin
    word_o    = 32'h0;
    imm_err_o = 1'b0;
    unique case (opcode_i[6:5])
      FMT_I: begin
        word_o    = {imm12, rs1_i, funct3_i, rd_i, opcode_i};
        imm_err_o = ~fits;
      end
      FMT_S_R: begin
        if (opcode_i[4]) begin
          word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
        end else begin
          word_o    = {imm12[11:5], rs2_i, rs1_i, funct3_i, imm12[4:0], opcode_i};
          imm_err_o = ~fits;
        end
      end
      default: begin
        // Branch layout with no implicit <<1: the field is the raw imm[11:0].
        word_o    = {imm12[11], imm12[9:4], rs2_i, rs1_i, funct3_i,
                     imm12[3:0], imm12[10], opcode_i};
        imm_err_o = ~fits;
      end
    endcase
  end

endmodule

// File: rtl/imm_instr_encoder.sv
// Instruction encoder top: accepts field bundles, writes packed words to
// instruction memory one cycle later at an auto-incrementing byte address.
module imm_instr_encoder
  import imm_instr_encoder_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned DEPTH     = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        restart,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_last,
  input  logic [6:0]                  opcode,
  input  logic [2:0]                  funct3,
  input  logic [6:0]                  funct7,
  input  logic [4:0]                  rd,
  input  logic [4:0]                  rs1,
  input  logic [4:0]                  rs2,
  input  logic [63:0]                 imm,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [31:0]                 mem_wdata,
  output logic                        imm_err,
  output logic                        err_any,
  output logic [$clog2(DEPTH+1)-1:0]  words_written,
  output logic                        done
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] BASE_C   = ADDR_W'(BASE_ADDR);
  localparam logic [CW-1:0]     DEPTH_M1 = CW'(DEPTH - 1);

  state_e              state_q;
  logic                mem_we_q, imm_err_q, err_any_q, err_any_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d, next_addr_q, next_addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [CW-1:0]       count_q, count_d;
  logic [31:0]         pk_word;
  logic                pk_err;
  logic                accept, last_word, restart_ok;

  instr_pack u_pack (
    .opcode_i  (opcode),
    .funct3_i  (funct3),
    .funct7_i  (funct7),
    .rd_i      (rd),
    .rs1_i     (rs1),
    .rs2_i     (rs2),
    .imm_i     (imm),
    .word_o    (pk_word),
    .imm_err_o (pk_err)
  );

  assign in_ready   = (state_q != ST_DONE);
  assign accept     = in_valid && in_ready;
  assign last_word  = in_last || (count_q == DEPTH_M1);
  assign restart_ok = (state_q == ST_DONE) && restart;

  // Session FSM: first accept leaves IDLE, the final word (flagged or depth-limited) ends in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_LOAD: if (accept) state_q <= last_word ? ST_DONE : ST_LOAD;
        ST_DONE:          if (restart) state_q <= ST_IDLE;
        default:          state_q <= ST_IDLE;
      endcase
    end
  end

  // Datapath next-state: capture word/address on accept, rewind the session on restart.
  always_comb begin
    wdata_d     = wdata_q;
    mem_addr_d  = mem_addr_q;
    next_addr_d = next_addr_q;
    count_d     = count_q;
    err_any_d   = err_any_q;
    if (accept) begin
      wdata_d     = pk_word;
      mem_addr_d  = next_addr_q;
      next_addr_d = next_addr_q + ADDR_W'(4);
      count_d     = count_q + CW'(1);
      err_any_d   = err_any_q | pk_err;
    end else if (restart_ok) begin
      mem_addr_d  = BASE_C;
      next_addr_d = BASE_C;
      count_d     = '0;
      err_any_d   = 1'b0;
    end
  end

  // Output register stage; reset also drops a write pending from the previous accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we_q    <= 1'b0;
      imm_err_q   <= 1'b0;
      err_any_q   <= 1'b0;
      mem_addr_q  <= BASE_C;
      next_addr_q <= BASE_C;
      wdata_q     <= 32'h0;
      count_q     <= '0;
    end else begin
      mem_we_q    <= accept;
      imm_err_q   <= accept & pk_err;
      err_any_q   <= err_any_d;
      mem_addr_q  <= mem_addr_d;
      next_addr_q <= next_addr_d;
      wdata_q     <= wdata_d;
      count_q     <= count_d;
    end
  end

  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = wdata_q;
  assign imm_err       = imm_err_q;
  assign err_any       = err_any_q;
  assign words_written = count_q;
  assign done          = (state_q == ST_DONE);

endmodule

// File: tb/tb_imm_instr_encoder.sv
// Directed bench for imm_instr_encoder: encoding table plus session corner cases.
module tb_imm_instr_encoder;
  import imm_instr_encoder_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, restart, in_valid, in_last;
  logic        in_ready, mem_we, imm_err, err_any, done;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [63:0] imm;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  words_written;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  imm_instr_encoder #(.ADDR_W(32), .BASE_ADDR(0), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .restart(restart),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .imm_err(imm_err), .err_any(err_any),
    .words_written(words_written), .done(done)
  );

  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] imm;
    logic [31:0] word;
    logic        err;
  } vec_t;

  vec_t vecs[9];

  function automatic vec_t mk(logic [6:0] opc, logic [2:0] f3, logic [6:0] f7,
                              logic [4:0] rdv, logic [4:0] r1, logic [4:0] r2,
                              logic [63:0] iv, logic [31:0] w, logic e);
    vec_t v;
    v.opc = opc; v.f3 = f3; v.f7 = f7; v.rd = rdv; v.rs1 = r1; v.rs2 = r2;
    v.imm = iv; v.word = w; v.err = e;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(vec_t v, logic last);
    in_valid = 1'b1; in_last = last;
    opcode = v.opc; funct3 = v.f3; funct7 = v.f7;
    rd = v.rd; rs1 = v.rs1; rs2 = v.rs2; imm = v.imm;
  endtask

  task automatic do_restart();
    in_valid = 1'b0; restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  initial begin
    vecs[0] = mk(OPC_LOAD,   3'b011, 7'h00, 5'd5, 5'd2, 5'd0, 64'hFFFF_FFFF_FFFF_FFF8, 32'hFF81_3283, 1'b0);
    vecs[1] = mk(OPC_STORE,  3'b011, 7'h00, 5'd0, 5'd2, 5'd5, 64'd16,                  32'h0051_3823, 1'b0);
    vecs[2] = mk(OPC_BRANCH, 3'b000, 7'h00, 5'd0, 5'd1, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE, 32'hFE20_8EE3, 1'b0);
    vecs[3] = mk(OPC_LOAD,   3'b011, 7'h00, 5'd5, 5'd2, 5'd0, 64'd2048,                32'h8001_3283, 1'b1);
    vecs[4] = mk(OPC_OP,     3'b000, 7'h20, 5'd1, 5'd2, 5'd3, 64'd2048,                32'h4031_00B3, 1'b0);
    vecs[5] = mk(7'b0010011, 3'b000, 7'h00, 5'd1, 5'd1, 5'd0, 64'hFFFF_FFFF_FFFF_F800, 32'h8000_8093, 1'b0);
    vecs[6] = mk(OPC_STORE,  3'b010, 7'h00, 5'd0, 5'd0, 5'd0, 64'd2047,                32'h7E00_2FA3, 1'b0);
    vecs[7] = mk(7'b1000011, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_F000, 32'h0000_0043, 1'b1);
    vecs[8] = mk(OPC_BRANCH, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 64'd2047,                32'h7E00_0FE3, 1'b0);

    reset = 1'b1; restart = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    opcode = '0; funct3 = '0; funct7 = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    tick(); tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_mem_we",   mem_we, 0);
    chk("rst_addr",     mem_addr, 0);
    chk("rst_wdata",    mem_wdata, 0);
    chk("rst_err",      {imm_err, err_any}, 0);
    chk("rst_count",    words_written, 0);
    chk("rst_done",     done, 0);
    reset = 1'b0;

    // Single-word sessions: each vector is a one-bundle program, IDLE -> DONE.
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i], 1'b1);
      tick();
      in_valid = 1'b0;
      chk($sformatf("v%0d_we", i),      mem_we, 1);
      chk($sformatf("v%0d_word", i),    mem_wdata, vecs[i].word);
      chk($sformatf("v%0d_addr", i),    mem_addr, 0);
      chk($sformatf("v%0d_imm_err", i), imm_err, vecs[i].err);
      chk($sformatf("v%0d_err_any", i), err_any, vecs[i].err);
      chk($sformatf("v%0d_done", i),    {done, in_ready, words_written}, {1'b1, 1'b0, 3'd1});
      tick();
      chk($sformatf("v%0d_we_off", i),  {mem_we, imm_err, err_any}, {1'b0, 1'b0, vecs[i].err});
      do_restart();
      #0;
      chk($sformatf("v%0d_restart", i), {done, in_ready, err_any, words_written}, {1'b1 ^ 1'b1, 1'b1, 1'b0, 3'd0});
    end

    // Back-to-back with a range error first: sticky err_any, addresses 0 then 4.
    drive(vecs[3], 1'b0);
    tick();
    chk("b2b_w0_addr", mem_addr, 0);
    chk("b2b_w0_flags", {mem_we, imm_err, err_any, done}, 4'b1110);
    drive(vecs[1], 1'b1);
    tick();
    in_valid = 1'b0;
    chk("b2b_w1_word", mem_wdata, 32'h0051_3823);
    chk("b2b_w1_addr", mem_addr, 4);
    chk("b2b_w1_flags", {mem_we, imm_err, err_any, done}, 4'b1011);
    chk("b2b_w1_count", words_written, 2);
    tick();
    chk("b2b_err_hold", {mem_we, err_any, done}, 3'b011);
    do_restart();

    // Depth limit: five bundles without in_last, restart held during LOAD (ignored).
    drive(vecs[0], 1'b0);
    for (int k = 0; k < 4; k++) begin
      restart = (k == 1);
      tick();
      chk($sformatf("dep%0d_we", k),    mem_we, 1);
      chk($sformatf("dep%0d_addr", k),  mem_addr, 4 * k);
      chk($sformatf("dep%0d_count", k), words_written, k + 1);
      chk($sformatf("dep%0d_done", k),  {done, in_ready}, (k == 3) ? 2'b10 : 2'b01);
    end
    restart = 1'b0;
    tick();
    chk("dep_fifth_dropped", {mem_we, words_written, done}, {1'b0, 3'd4, 1'b1});
    do_restart();
    chk("dep_restart", {done, in_ready, words_written, mem_addr}, {1'b0, 1'b1, 3'd0, 32'd0});
    drive(vecs[2], 1'b0);
    tick();
    in_valid = 1'b0;
    chk("dep_after_restart", {mem_we, words_written, mem_addr, mem_wdata},
        {1'b1, 3'd1, 32'd0, 32'hFE20_8EE3});

    // Reset mid-load: the bundle presented alongside reset must not be written.
    drive(vecs[1], 1'b0);
    tick();
    chk("rml_accept", {mem_we, mem_addr, words_written}, {1'b1, 32'd4, 3'd2});
    reset = 1'b1;
    tick();
    chk("rml_reset", {mem_we, mem_addr, words_written, done, in_ready, err_any},
        {1'b0, 32'd0, 3'd0, 1'b0, 1'b1, 1'b0});
    reset = 1'b0; in_valid = 1'b0;
    tick();
    chk("rml_quiet", {mem_we, words_written}, {1'b0, 3'd0});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
